// File: rtl/fifo_pkg.sv
// Shared definitions for the async byte FIFO and its read-side packer.
package fifo_pkg;

  typedef enum logic {FILL, HOLD} pk_state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_WORD_BYTES = 4;

endpackage

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs WORD_BYTES popped entries little-endian into one
// valid/ready word, with flush emitting a partial word plus byte-keep mask.
//
// state | meaning
// FILL  | popping entries into lanes of the word under construction
// HOLD  | word presented on m_valid, waiting for m_ready
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int CNT_W      = 16
) (
  input  logic                         rclk,
  input  logic                         rrst_n,
  input  logic                         rempty,
  input  logic [DATA_W-1:0]            rdata,
  output logic                         rinc,
  input  logic                         flush,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_W*WORD_BYTES-1:0] m_data,
  output logic [WORD_BYTES-1:0]        m_keep,
  output logic                         m_last,
  output logic [CNT_W-1:0]             word_cnt
);

  localparam int                WORD_W   = DATA_W * WORD_BYTES;
  localparam int                IDX_W    = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);

  pk_state_e               state;
  logic [IDX_W-1:0]        byte_idx;
  logic                    pop;
  logic                    word_done;
  logic                    fill_flush;
  logic [IDX_W-1:0]        last_idx;
  logic [WORD_BYTES-1:0]   flush_keep;

  // Gated by reset so the FIFO is never popped while the packer is held in reset.
  assign pop  = rrst_n && !rempty && ((state == FILL) || ((state == HOLD) && m_ready));
  assign rinc = pop;

  assign word_done  = pop && (byte_idx == LAST_IDX);
  assign fill_flush = flush && ((byte_idx != '0) || pop);

  // Highest lane holding data once this edge completes; a same-cycle pop counts.
  always_comb begin
    last_idx   = pop ? byte_idx : (byte_idx - IDX_W'(1));
    flush_keep = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      flush_keep[k] = (IDX_W'(k) <= last_idx);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= FILL;
      byte_idx <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      m_last   <= 1'b0;
      word_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (pop) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
              if (IDX_W'(k) == byte_idx) m_data[k*DATA_W +: DATA_W] <= rdata;
            end
          end
          if (word_done) begin
            state    <= HOLD;
            m_valid  <= 1'b1;
            m_keep   <= '1;
            m_last   <= flush;
            byte_idx <= '0;
          end else if (fill_flush) begin
            state    <= HOLD;
            m_valid  <= 1'b1;
            m_keep   <= flush_keep;
            m_last   <= 1'b1;
            byte_idx <= '0;
          end else if (pop) begin
            byte_idx <= byte_idx + IDX_W'(1);
          end
        end
        HOLD: begin
          if (m_ready) begin
            state    <= FILL;
            word_cnt <= word_cnt + CNT_W'(1);
            m_valid  <= 1'b0;
            m_keep   <= '0;
            m_last   <= 1'b0;
            // A pop on the accepting edge starts the next word without a bubble.
            if (pop) begin
              m_data   <= WORD_W'(rdata);
              byte_idx <= IDX_W'(1);
            end else begin
              m_data   <= '0;
              byte_idx <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural fall-through FIFO plus a byte-list word model.
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic [15:0] word_cnt;

  fifo_rd_packer dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last), .word_cnt(word_cnt)
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q[$];
  logic        gate;
  logic [7:0]  cur[$];
  bit          hold;
  logic [31:0] e_data;
  logic [3:0]  e_keep;
  bit          e_last;
  logic [15:0] e_cnt;
  logic [31:0] got[$];
  int          pops;
  bit          rinc_s;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic drive_fifo();
    rempty = gate || (q.size() == 0);
    rdata  = (q.size() > 0) ? q[0] : 8'($urandom);
  endtask

  task automatic model_reset();
    cur.delete();
    hold  = 0;
    e_cnt = '0;
  endtask

  // One rclk cycle: inputs already set after a falling edge; ends at the next falling edge.
  task automatic step();
    bit         e_rinc, ready_s, flush_s, hs;
    logic [7:0] b;
    logic [31:0] hs_data;
    drive_fifo();
    #1;
    e_rinc = !rempty && (!hold || m_ready);
    chk("rinc", rinc, e_rinc);
    rinc_s  = rinc;
    ready_s = m_ready;
    flush_s = flush;
    b       = rdata;
    hs      = m_valid && m_ready;
    hs_data = m_data;
    @(posedge rclk);
    if (hs) got.push_back(hs_data);
    if (rinc_s) begin
      pops++;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (hold) begin
      if (ready_s) begin
        e_cnt++;
        hold = 0;
        cur.delete();
        if (e_rinc) cur.push_back(b);
      end
    end else begin
      if (e_rinc) cur.push_back(b);
      if (cur.size() == 4 || (flush_s && cur.size() > 0)) begin
        hold   = 1;
        e_data = '0;
        foreach (cur[i]) e_data |= 32'(cur[i]) << (8 * i);
        e_keep = 4'((1 << cur.size()) - 1);
        e_last = flush_s;
        cur.delete();
      end
    end
    @(negedge rclk);
    chk("m_valid", m_valid, hold);
    if (hold) begin
      chk("m_data", m_data, e_data);
      chk("m_keep", m_keep, e_keep);
      chk("m_last", m_last, e_last);
    end
    chk("word_cnt", word_cnt, e_cnt);
  endtask

  initial begin
    rrst_n = 1'b0; m_ready = 1'b0; flush = 1'b0; gate = 1'b0; pops = 0;
    model_reset();
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    drive_fifo();
    #2;
    chk("rst_rinc", rinc, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_keep", m_keep, 0);
    chk("rst_cnt", word_cnt, 0);
    @(negedge rclk);
    rrst_n = 1'b1;

    // streaming, two full words
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("stream_pop_run", pops, 8);
    step(); step();
    chk("stream_pops", pops, 8);
    chk("stream_nwords", got.size(), 2);
    if (got.size() >= 2) begin
      chk("stream_w0", got[0], 32'h04030201);
      chk("stream_w1", got[1], 32'h08070605);
    end
    chk("stream_cnt", word_cnt, 2);

    // backpressure with data queued
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) q.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_rinc", rinc_s, 0);
      chk("bp_data", m_data, 32'h14131211);
    end
    m_ready = 1'b1;
    step();
    chk("bp_pop", rinc_s, 1);
    chk("bp_cnt", word_cnt, 3);
    m_ready = 1'b0; flush = 1'b1;
    step();
    chk("bp_tail_data", m_data, 32'h00000015);
    chk("bp_tail_keep", m_keep, 4'b0001);
    flush = 1'b0; m_ready = 1'b1;
    step();

    // partial flush
    q.push_back(8'h05); q.push_back(8'h06);
    step(); step();
    m_ready = 1'b0; flush = 1'b1;
    step();
    chk("pf_data", m_data, 32'h00000605);
    chk("pf_keep", m_keep, 4'b0011);
    chk("pf_last", m_last, 1);
    flush = 1'b0; m_ready = 1'b1;
    step();

    // flush with nothing held, then flush with the 3rd pop
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fe_valid", m_valid, 0);
    end
    flush = 1'b0; m_ready = 1'b0;
    q.push_back(8'h21); q.push_back(8'h22); q.push_back(8'h23);
    step(); step();
    flush = 1'b1;
    step();
    chk("f3_keep", m_keep, 4'b0111);
    chk("f3_data", m_data, 32'h00232221);
    flush = 1'b0; m_ready = 1'b1;
    step();

    // reset mid-word
    q.push_back(8'h31); q.push_back(8'h32);
    step(); step();
    rrst_n = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(8'h0A + 8'(i));
    drive_fifo();
    #1;
    model_reset();
    chk("mr_rinc", rinc, 0);
    chk("mr_valid", m_valid, 0);
    chk("mr_keep", m_keep, 0);
    chk("mr_cnt", word_cnt, 0);
    @(negedge rclk);
    rrst_n = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mr_data", m_data, 32'h0D0C0B0A);
    chk("mr_keep_full", m_keep, 4'hF);
    m_ready = 1'b1;
    step();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) != 0) q.push_back(8'($urandom));
      gate    = ($urandom_range(0, 7) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
